// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns PC and IR, fetches one word per strobe over a
// ready-handshaked memory port, applies branch redirects and slices the IR.
module fetch_unit #(
    parameter int unsigned            ADDR_W   = 16,
    parameter logic [ADDR_W-1:0]      RESET_PC = '0,
    parameter int unsigned            TIMEOUT  = 15
) (
    input  logic              clk,
    input  logic              rst_f,
    input  logic              fetch_req,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_addr,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rdy,
    input  logic [31:0]       imem_data,
    output logic [ADDR_W-1:0] pc,
    output logic [31:0]       ir,
    output logic [3:0]        opcode,
    output logic [3:0]        mm,
    output logic [3:0]        rd,
    output logic [3:0]        rs,
    output logic [3:0]        rt,
    output logic [15:0]       imm,
    output logic              ir_valid,
    output logic              busy,
    output logic              halted,
    output logic              fetch_err
);

    localparam int unsigned CNT_W  = 8;
    localparam logic [3:0]  OP_HLT = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_HALT,
        S_ERR
    } state_t;

    state_t              state_q, state_n;
    logic [ADDR_W-1:0]   pc_q, pc_n;
    logic [ADDR_W-1:0]   tgt_q, tgt_n;
    logic                pend_q, pend_n;
    logic [CNT_W-1:0]    cnt_q, cnt_n;
    logic [31:0]         ir_n;
    logic                ir_valid_n;

    // Next-state and datapath updates
    always_comb begin
        state_n    = state_q;
        pc_n       = pc_q;
        tgt_n      = tgt_q;
        pend_n     = pend_q;
        cnt_n      = cnt_q;
        ir_n       = ir;
        ir_valid_n = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Branch lands in pc first so a same-cycle fetch uses the target
                if (br_taken) pc_n = br_addr;
                if (fetch_req) begin
                    state_n = S_REQ;
                    cnt_n   = '0;
                    pend_n  = 1'b0;
                end
            end
            S_REQ: begin
                if (br_taken) begin
                    pend_n = 1'b1;
                    tgt_n  = br_addr;
                end
                if (imem_rdy) begin
                    ir_n       = imem_data;
                    pc_n       = pend_q ? tgt_q : pc_q + ADDR_W'(1);
                    pend_n     = 1'b0;
                    cnt_n      = '0;
                    ir_valid_n = 1'b1;
                    state_n    = (imem_data[31:28] == OP_HLT) ? S_HALT : S_IDLE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    cnt_n   = cnt_q + CNT_W'(1);
                    state_n = S_ERR;
                end else begin
                    cnt_n = cnt_q + CNT_W'(1);
                end
            end
            S_HALT: state_n = S_HALT;
            S_ERR:  state_n = S_ERR;
            default: state_n = S_IDLE;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst_f) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            tgt_q     <= '0;
            pend_q    <= 1'b0;
            cnt_q     <= '0;
            ir        <= '0;
            ir_valid  <= 1'b0;
            imem_req  <= 1'b0;
            busy      <= 1'b0;
            halted    <= 1'b0;
            fetch_err <= 1'b0;
        end else begin
            state_q   <= state_n;
            pc_q      <= pc_n;
            tgt_q     <= tgt_n;
            pend_q    <= pend_n;
            cnt_q     <= cnt_n;
            ir        <= ir_n;
            ir_valid  <= ir_valid_n;
            imem_req  <= (state_n == S_REQ);
            busy      <= (state_n == S_REQ);
            halted    <= (state_n == S_HALT);
            fetch_err <= (state_n == S_ERR);
        end
    end

    assign pc        = pc_q;
    assign imem_addr = pc_q;
    assign opcode    = ir[31:28];
    assign mm        = ir[27:24];
    assign rd        = ir[23:20];
    assign rs        = ir[19:16];
    assign rt        = ir[15:12];
    assign imm       = ir[15:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: driver pushes expected fetch addresses and
// results; a negedge monitor pops and compares when the DUT presents them.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_f = 1'b1;
    logic        fetch_req = 1'b0;
    logic        br_taken = 1'b0;
    logic [15:0] br_addr = '0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_rdy = 1'b0;
    logic [31:0] imem_data = '0;
    logic [15:0] pc;
    logic [31:0] ir;
    logic [3:0]  opcode, mm, rd, rs, rt;
    logic [15:0] imm;
    logic        ir_valid, busy, halted, fetch_err;

    fetch_unit #(.ADDR_W(16), .RESET_PC(16'h0000), .TIMEOUT(15)) dut (
        .clk(clk), .rst_f(rst_f), .fetch_req(fetch_req), .br_taken(br_taken),
        .br_addr(br_addr), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdy(imem_rdy), .imem_data(imem_data), .pc(pc), .ir(ir),
        .opcode(opcode), .mm(mm), .rd(rd), .rs(rs), .rt(rt), .imm(imm),
        .ir_valid(ir_valid), .busy(busy), .halted(halted), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ir;
        logic [15:0] pc;
        logic        halted;
    } res_t;

    int          checks = 0;
    int          failures = 0;
    logic [15:0] exp_addr[$];
    res_t        exp_res[$];
    logic [15:0] m_pc = '0;
    logic [31:0] m_ir = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: address on request rise / stability, and result on ir_valid
    logic        prev_req = 1'b0;
    logic        prev_iv = 1'b0;
    logic [15:0] cur_addr = '0;
    always @(negedge clk) begin
        if (imem_req === 1'b1 && prev_req !== 1'b1) begin
            if (exp_addr.size() == 0) chk("unexpected_imem_req", 32'(imem_addr), 32'hFFFF_FFFF);
            else begin
                cur_addr = exp_addr.pop_front();
                chk("imem_addr", 32'(imem_addr), 32'(cur_addr));
            end
        end else if (imem_req === 1'b1) begin
            chk("imem_addr_stable", 32'(imem_addr), 32'(cur_addr));
        end
        if (ir_valid === 1'b1) begin
            if (prev_iv === 1'b1) chk("ir_valid_width", 32'(prev_iv), 32'(0));
            if (exp_res.size() == 0) chk("unexpected_ir_valid", 32'(ir_valid), 32'(0));
            else begin
                res_t r;
                r = exp_res.pop_front();
                chk("ir", ir, r.ir);
                chk("opcode", 32'(opcode), 32'(r.ir[31:28]));
                chk("mm", 32'(mm), 32'(r.ir[27:24]));
                chk("rd", 32'(rd), 32'(r.ir[23:20]));
                chk("rs", 32'(rs), 32'(r.ir[19:16]));
                chk("rt", 32'(rt), 32'(r.ir[15:12]));
                chk("imm", 32'(imm), 32'(r.ir[15:0]));
                chk("pc_after_fetch", 32'(pc), 32'(r.pc));
                chk("halted_on_capture", 32'(halted), 32'(r.halted));
                chk("req_drop", 32'(imem_req), 32'(0));
                chk("busy_drop", 32'(busy), 32'(0));
            end
        end
        prev_req = imem_req;
        prev_iv  = ir_valid;
    end

    task automatic do_reset();
        rst_f = 1'b1;
        @(posedge clk); #1;
        rst_f = 1'b0;
        m_pc = '0;
        m_ir = '0;
    endtask

    task automatic pulse_fetch(input bit br, input logic [15:0] ba);
        fetch_req = 1'b1; br_taken = br; br_addr = ba;
        @(posedge clk); #1;
        fetch_req = 1'b0; br_taken = 1'b0;
    endtask

    task automatic branch_only(input logic [15:0] ba);
        br_taken = 1'b1; br_addr = ba;
        @(posedge clk); #1;
        br_taken = 1'b0;
        m_pc = ba;
    endtask

    task automatic do_fetch(input bit br, input logic [15:0] ba, input int waits,
                            input logic [31:0] data, input bit mid_br,
                            input logic [15:0] mba, input bit extra_req);
        logic [15:0] addr;
        if (br) m_pc = ba;
        addr = m_pc;
        m_pc = (mid_br && waits > 0) ? mba : addr + 16'd1;
        m_ir = data;
        exp_addr.push_back(addr);
        exp_res.push_back('{data, m_pc, data[31:28] == 4'hF});
        pulse_fetch(br, ba);
        chk("busy_in_req", 32'(busy), 32'(1));
        for (int i = 0; i < waits; i++) begin
            if (i == 0 && mid_br) begin br_taken = 1'b1; br_addr = mba; end
            if (i == waits - 1 && extra_req) fetch_req = 1'b1;
            @(posedge clk); #1;
            br_taken = 1'b0; fetch_req = 1'b0;
        end
        imem_rdy = 1'b1; imem_data = data;
        @(posedge clk); #1;
        imem_rdy = 1'b0; imem_data = $urandom;
    endtask

    initial begin
        int cnt;
        logic [31:0] d;
        logic [15:0] a;

        do_reset();
        chk("rst_pc", 32'(pc), 32'(0));
        chk("rst_ir", ir, 32'(0));
        chk("rst_imem_req", 32'(imem_req), 32'(0));
        chk("rst_ir_valid", 32'(ir_valid), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_halted", 32'(halted), 32'(0));
        chk("rst_fetch_err", 32'(fetch_err), 32'(0));

        // Basic decode, then varied wait counts with an ignored mid-request strobe
        do_fetch(0, '0, 1, 32'h8123_4005, 0, '0, 0);
        @(posedge clk); #1;
        do_reset();
        do_fetch(0, '0, 0, 32'h1111_1111, 0, '0, 0);
        do_fetch(0, '0, 2, 32'h2222_2222, 0, '0, 0);
        do_fetch(0, '0, 5, 32'h3333_3333, 0, '0, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("pc_after_three", 32'(pc), 32'(3));
        chk("no_queued_fetch", 32'(imem_req), 32'(0));

        // Branch with fetch, branch pending during a wait, and wrap at all-ones
        do_fetch(1, 16'h0040, 0, 32'h4000_0040, 0, '0, 0);
        do_fetch(0, '0, 3, 32'h5000_0000, 1, 16'h0100, 0);
        branch_only(16'hFFFF);
        chk("pc_preload", 32'(pc), 32'(16'hFFFF));
        do_fetch(0, '0, 1, 32'h6000_0001, 0, '0, 0);

        // Randomized traffic
        for (int k = 0; k < 40; k++) begin
            d = $urandom;
            if (d[31:28] == 4'hF) d[31] = 1'b0;
            a = 16'($urandom);
            if ($urandom_range(0, 4) == 0) branch_only(16'($urandom));
            do_fetch(bit'($urandom_range(0, 1)), a, int'($urandom_range(0, 8)), d,
                     bit'($urandom_range(0, 1)), 16'($urandom), bit'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        // Halt: further strobes are ignored until reset
        do_fetch(0, '0, 1, 32'hF000_0000, 0, '0, 0);
        pulse_fetch(1, 16'h1234);
        repeat (3) begin
            chk("halt_no_req", 32'(imem_req), 32'(0));
            @(posedge clk); #1;
        end
        chk("halt_pc_frozen", 32'(pc), 32'(m_pc));
        chk("halt_ir_frozen", ir, 32'hF000_0000);
        chk("halted_sticky", 32'(halted), 32'(1));
        do_reset();
        chk("halt_rst_halted", 32'(halted), 32'(0));
        chk("halt_rst_pc", 32'(pc), 32'(0));

        // Timeout into sticky error
        do_fetch(0, '0, 0, 32'h7000_0007, 0, '0, 0);
        exp_addr.push_back(m_pc);
        pulse_fetch(0, '0);
        cnt = 0;
        while (imem_req === 1'b1 && cnt < 100) begin
            cnt++;
            @(posedge clk); #1;
        end
        chk("timeout_req_cycles", 32'(cnt), 32'(15));
        chk("timeout_fetch_err", 32'(fetch_err), 32'(1));
        chk("timeout_imem_req", 32'(imem_req), 32'(0));
        chk("timeout_pc", 32'(pc), 32'(m_pc));
        chk("timeout_ir", ir, m_ir);
        pulse_fetch(0, '0);
        @(posedge clk); #1;
        chk("err_no_req", 32'(imem_req), 32'(0));
        chk("err_sticky", 32'(fetch_err), 32'(1));

        // Reset during a request; a late ready must be ignored
        do_reset();
        chk("err_cleared", 32'(fetch_err), 32'(0));
        exp_addr.push_back(16'h0000);
        pulse_fetch(0, '0);
        @(posedge clk); #1;
        rst_f = 1'b1;
        @(posedge clk); #1;
        rst_f = 1'b0;
        imem_rdy = 1'b1; imem_data = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        imem_rdy = 1'b0;
        @(posedge clk); #1;
        chk("late_rdy_ir", ir, 32'(0));
        chk("late_rdy_pc", 32'(pc), 32'(0));
        chk("late_rdy_req", 32'(imem_req), 32'(0));

        repeat (3) @(posedge clk);
        #1;
        chk("addr_queue_drained", 32'(exp_addr.size()), 32'(0));
        chk("result_queue_drained", 32'(exp_res.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
